// File: rtl/game_frame_compositor.sv
// Pixel colouring, per-frame collision statistics and game-over overlay for the
// game-logic pixel stream. Two-stage pixel pipeline; frame FSM runs alongside.
module game_frame_compositor #(
  parameter int SCREEN_WIDTH     = 1280,
  parameter int SCREEN_HEIGHT    = 720,
  parameter int GOAL_DEPTH       = 60,
  parameter int GOAL_DEPTH_DELTA = 10,
  parameter int FLASH_FRAMES     = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        data_valid_in,
  input  logic [7:0]  wall_depth_in,
  input  logic [7:0]  player_depth_in,
  input  logic        is_wall_in,
  input  logic        is_person_in,
  input  logic        is_collision_in,
  input  logic [2:0]  game_state_in,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic        data_valid_out,
  output logic [23:0] pixel_out,
  output logic [19:0] frame_collisions_out,
  output logic        frame_stats_valid_out,
  output logic        flash_active_out
);

  typedef enum logic [1:0] {ST_PLAY, ST_FLASH, ST_OVER} state_t;

  localparam int GOAL_LO = GOAL_DEPTH - GOAL_DEPTH_DELTA;
  localparam int GOAL_HI = GOAL_DEPTH + GOAL_DEPTH_DELTA;

  state_t      state_q, state_d;
  logic [7:0]  flash_cnt_q, flash_cnt_d;
  logic [19:0] coll_cnt_q, coll_cnt_d, coll_cnt_inc;
  logic [19:0] frame_coll_q, frame_coll_d;
  logic        stats_valid_q, stats_valid_d;

  logic        s1_valid_q, s1_valid_d;
  logic [10:0] s1_h_q, s1_h_d;
  logic [9:0]  s1_v_q, s1_v_d;
  logic        s1_coll_q, s1_coll_d, s1_wall_q, s1_wall_d, s1_person_q, s1_person_d;
  logic        s1_goal_q, s1_goal_d;
  logic [7:0]  s1_shade_q, s1_shade_d, s1_pdepth_q, s1_pdepth_d;
  state_t      s1_state_q, s1_state_d;
  logic        s1_cnt0_q, s1_cnt0_d;

  logic        s2_valid_q, s2_valid_d;
  logic [10:0] s2_h_q, s2_h_d;
  logic [9:0]  s2_v_q, s2_v_d;
  logic [23:0] s2_pixel_q, s2_pixel_d;

  logic        frame_end;
  logic [23:0] base_rgb;

  assign frame_end = data_valid_in && (hcount_in == 11'(SCREEN_WIDTH - 1)) &&
                     (vcount_in == 10'(SCREEN_HEIGHT - 1));

  // Frame FSM: a restart (nonzero game state) wins over frame-end counting.
  always_comb begin
    state_d     = state_q;
    flash_cnt_d = flash_cnt_q;
    case (state_q)
      ST_PLAY: begin
        if (game_state_in == 3'd0) begin
          state_d     = ST_FLASH;
          flash_cnt_d = 8'd0;
        end
      end
      ST_FLASH: begin
        if (game_state_in != 3'd0) begin
          state_d = ST_PLAY;
        end else if (frame_end) begin
          flash_cnt_d = flash_cnt_q + 8'd1;
          if (flash_cnt_q == 8'(FLASH_FRAMES - 1)) state_d = ST_OVER;
        end
      end
      ST_OVER: begin
        if (game_state_in != 3'd0) state_d = ST_PLAY;
      end
      default: state_d = ST_PLAY;
    endcase
  end

  always_comb begin
    coll_cnt_inc = coll_cnt_q;
    if (data_valid_in && is_collision_in && (coll_cnt_q != '1)) coll_cnt_inc = coll_cnt_q + 20'd1;
    coll_cnt_d    = coll_cnt_inc;
    frame_coll_d  = frame_coll_q;
    stats_valid_d = 1'b0;
    if (frame_end) begin
      frame_coll_d  = coll_cnt_inc;
      stats_valid_d = 1'b1;
      coll_cnt_d    = 20'd0;
    end
  end

  always_comb begin
    s1_valid_d  = data_valid_in;
    s1_h_d      = hcount_in;
    s1_v_d      = vcount_in;
    s1_coll_d   = is_collision_in;
    s1_wall_d   = is_wall_in;
    s1_person_d = is_person_in;
    s1_goal_d   = ($signed({24'd0, wall_depth_in}) >= GOAL_LO) &&
                  ($signed({24'd0, wall_depth_in}) <= GOAL_HI);
    s1_shade_d  = wall_depth_in[7] ? 8'hFF : {wall_depth_in[6:0], 1'b0};
    s1_pdepth_d = player_depth_in;
    s1_state_d  = state_q;
    s1_cnt0_d   = flash_cnt_q[0];
  end

  always_comb begin
    base_rgb = 24'h000000;
    if (s1_coll_q)        base_rgb = 24'hFF0000;
    else if (s1_wall_q)   base_rgb = s1_goal_q ? {8'h00, s1_shade_q, 8'h00} : {16'h0000, s1_shade_q};
    else if (s1_person_q) base_rgb = {s1_pdepth_q, s1_pdepth_q, s1_pdepth_q};
    s2_valid_d = s1_valid_q;
    s2_h_d     = s1_h_q;
    s2_v_d     = s1_v_q;
    s2_pixel_d = 24'h000000;
    if (s1_valid_q) begin
      s2_pixel_d = base_rgb;
      if (s1_state_q == ST_FLASH && !s1_cnt0_q) s2_pixel_d = base_rgb ^ 24'hFFFFFF;
      if (s1_state_q == ST_OVER)
        s2_pixel_d = {1'b0, base_rgb[23:17], 1'b0, base_rgb[15:9], 1'b0, base_rgb[7:1]};
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q       <= ST_PLAY;
      flash_cnt_q   <= 8'd0;
      coll_cnt_q    <= 20'd0;
      frame_coll_q  <= 20'd0;
      stats_valid_q <= 1'b0;
      s1_valid_q    <= 1'b0;
      s1_h_q        <= 11'd0;
      s1_v_q        <= 10'd0;
      s1_coll_q     <= 1'b0;
      s1_wall_q     <= 1'b0;
      s1_person_q   <= 1'b0;
      s1_goal_q     <= 1'b0;
      s1_shade_q    <= 8'd0;
      s1_pdepth_q   <= 8'd0;
      s1_state_q    <= ST_PLAY;
      s1_cnt0_q     <= 1'b0;
      s2_valid_q    <= 1'b0;
      s2_h_q        <= 11'd0;
      s2_v_q        <= 10'd0;
      s2_pixel_q    <= 24'd0;
    end else begin
      state_q       <= state_d;
      flash_cnt_q   <= flash_cnt_d;
      coll_cnt_q    <= coll_cnt_d;
      frame_coll_q  <= frame_coll_d;
      stats_valid_q <= stats_valid_d;
      s1_valid_q    <= s1_valid_d;
      s1_h_q        <= s1_h_d;
      s1_v_q        <= s1_v_d;
      s1_coll_q     <= s1_coll_d;
      s1_wall_q     <= s1_wall_d;
      s1_person_q   <= s1_person_d;
      s1_goal_q     <= s1_goal_d;
      s1_shade_q    <= s1_shade_d;
      s1_pdepth_q   <= s1_pdepth_d;
      s1_state_q    <= s1_state_d;
      s1_cnt0_q     <= s1_cnt0_d;
      s2_valid_q    <= s2_valid_d;
      s2_h_q        <= s2_h_d;
      s2_v_q        <= s2_v_d;
      s2_pixel_q    <= s2_pixel_d;
    end
  end

  assign hcount_out            = s2_h_q;
  assign vcount_out            = s2_v_q;
  assign data_valid_out        = s2_valid_q;
  assign pixel_out             = s2_pixel_q;
  assign frame_collisions_out  = frame_coll_q;
  assign frame_stats_valid_out = stats_valid_q;
  assign flash_active_out      = (state_q == ST_FLASH);

endmodule

// File: tb/tb_game_frame_compositor.sv
// Directed bench for game_frame_compositor: queued expected pixels and frame
// statistics, checked by a monitor whenever the DUT presents them.
module tb_game_frame_compositor;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        data_valid_in;
  logic [7:0]  wall_depth_in, player_depth_in;
  logic        is_wall_in, is_person_in, is_collision_in;
  logic [2:0]  game_state_in;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic        data_valid_out;
  logic [23:0] pixel_out;
  logic [19:0] frame_collisions_out;
  logic        frame_stats_valid_out;
  logic        flash_active_out;

  int          checks = 0;
  int          failures = 0;
  logic [44:0] exp_pix_q[$];
  logic [19:0] exp_stats_q[$];
  logic [2:0]  cur_gs = 3'd1;
  logic        prev_stats = 1'b0;

  game_frame_compositor dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .hcount_in(hcount_in), .vcount_in(vcount_in), .data_valid_in(data_valid_in),
    .wall_depth_in(wall_depth_in), .player_depth_in(player_depth_in),
    .is_wall_in(is_wall_in), .is_person_in(is_person_in), .is_collision_in(is_collision_in),
    .game_state_in(game_state_in),
    .hcount_out(hcount_out), .vcount_out(vcount_out), .data_valid_out(data_valid_out),
    .pixel_out(pixel_out), .frame_collisions_out(frame_collisions_out),
    .frame_stats_valid_out(frame_stats_valid_out), .flash_active_out(flash_active_out)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive(input logic v, input logic [10:0] h, input logic [9:0] vc,
                       input logic [7:0] wd, input logic [7:0] pd,
                       input logic wall, input logic person, input logic coll);
    @(posedge clk_in);
    #1;
    data_valid_in   = v;
    hcount_in       = h;
    vcount_in       = vc;
    wall_depth_in   = wd;
    player_depth_in = pd;
    is_wall_in      = wall;
    is_person_in    = person;
    is_collision_in = coll;
    game_state_in   = cur_gs;
  endtask

  task automatic pix(input logic [10:0] h, input logic [9:0] vc, input logic [7:0] wd,
                     input logic [7:0] pd, input logic wall, input logic person,
                     input logic coll, input logic [23:0] exp_p);
    drive(1'b1, h, vc, wd, pd, wall, person, coll);
    exp_pix_q.push_back({h, vc, exp_p});
  endtask

  // Invalid cycle carrying frame-end coordinates and a collision: must be ignored.
  task automatic idle();
    drive(1'b0, 11'd1279, 10'd719, 8'd200, 8'd200, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic frame_end(input logic coll, input logic [23:0] exp_p, input logic [19:0] exp_s);
    pix(11'd1279, 10'd719, 8'd0, 8'd0, 1'b0, 1'b0, coll, exp_p);
    exp_stats_q.push_back(exp_s);
    idle();
  endtask

  task automatic set_gs(input logic [2:0] g);
    cur_gs = g;
    idle();
    idle();
  endtask

  // scoreboard monitor
  task automatic monitor();
    logic [44:0] e;
    logic [19:0] s;
    forever begin
      @(negedge clk_in);
      if (!rst_in) begin
        prev_stats = 1'b0;
      end else begin
        if (data_valid_out) begin
          if (exp_pix_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL pixel_unexpected actual=%h expected=none", {hcount_out, vcount_out, pixel_out});
          end else begin
            e = exp_pix_q.pop_front();
            chk("pixel_hv_rgb", {hcount_out, vcount_out, pixel_out}, e);
          end
        end else begin
          chk("blank_pixel", pixel_out, 24'd0);
        end
        if (frame_stats_valid_out) begin
          chk("stats_pulse_width", prev_stats, 1'b0);
          if (exp_stats_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL stats_unexpected actual=%0d expected=none", frame_collisions_out);
          end else begin
            s = exp_stats_q.pop_front();
            chk("frame_collisions", frame_collisions_out, s);
          end
        end
        prev_stats = frame_stats_valid_out;
      end
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_pixel"}, pixel_out, 24'd0);
    chk({tag, "_frame_coll"}, frame_collisions_out, 20'd0);
    chk({tag, "_stats_valid"}, frame_stats_valid_out, 1'b0);
    chk({tag, "_flash"}, flash_active_out, 1'b0);
    chk({tag, "_dv"}, data_valid_out, 1'b0);
    chk({tag, "_hcount"}, hcount_out, 11'd0);
    chk({tag, "_vcount"}, vcount_out, 10'd0);
  endtask

  initial begin
    rst_in = 1'b0;
    data_valid_in = 1'b0; hcount_in = '0; vcount_in = '0;
    wall_depth_in = '0; player_depth_in = '0;
    is_wall_in = 1'b0; is_person_in = 1'b0; is_collision_in = 1'b0;
    game_state_in = 3'd1;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk_in);
    #1;
    chk_outputs_zero("reset");
    @(negedge clk_in);
    rst_in = 1'b1;

    // Colour mapping (one collision pixel here counts toward frame 1)
    pix(11'd10, 10'd20, 8'd60,  8'd0,  1, 0, 0, 24'h007800);
    pix(11'd11, 10'd20, 8'd30,  8'd0,  1, 0, 0, 24'h00003C);
    pix(11'd12, 10'd20, 8'd200, 8'd0,  1, 0, 0, 24'h0000FF);
    pix(11'd13, 10'd20, 8'd50,  8'd0,  1, 0, 0, 24'h006400);
    pix(11'd14, 10'd20, 8'd70,  8'd0,  1, 0, 0, 24'h008C00);
    pix(11'd15, 10'd20, 8'd71,  8'd0,  1, 0, 0, 24'h00008E);
    pix(11'd16, 10'd20, 8'd49,  8'd0,  1, 0, 0, 24'h000062);
    pix(11'd17, 10'd20, 8'd128, 8'd0,  1, 0, 0, 24'h0000FF);
    pix(11'd18, 10'd20, 8'd0,   8'hC8, 0, 1, 0, 24'hC8C8C8);
    pix(11'd19, 10'd20, 8'd60,  8'h40, 1, 1, 1, 24'hFF0000);
    pix(11'd20, 10'd20, 8'd0,   8'd0,  0, 0, 0, 24'h000000);
    idle();
    idle();

    // Frame 1: 1 earlier + 3 near-miss/ordinary + final pixel = 5
    pix(11'd1279, 10'd718, 8'd0, 8'd0, 0, 0, 1, 24'hFF0000);
    pix(11'd1278, 10'd719, 8'd0, 8'd0, 0, 0, 1, 24'hFF0000);
    idle();
    pix(11'd5, 10'd5, 8'd0, 8'd0, 0, 1, 1, 24'hFF0000);
    frame_end(1'b1, 24'hFF0000, 20'd5);
    pix(11'd6, 10'd6, 8'd90, 8'd0, 1, 0, 0, 24'h0000B4);
    frame_end(1'b0, 24'h000000, 20'd0);

    // Game over: flash sequence then dimmed hold
    set_gs(3'd0);
    chk("flash_after_drop", flash_active_out, 1'b1);
    pix(11'd30, 10'd30, 8'd0, 8'd0, 0, 0, 0, 24'hFFFFFF);
    frame_end(1'b0, 24'hFFFFFF, 20'd0);
    pix(11'd31, 10'd30, 8'd0, 8'd0, 0, 0, 0, 24'h000000);
    for (int k = 2; k <= 8; k++) begin
      frame_end(1'b0, (k % 2 == 1) ? 24'hFFFFFF : 24'h000000, 20'd0);
      if (k == 7) chk("flash_before_last", flash_active_out, 1'b1);
    end
    chk("flash_in_over", flash_active_out, 1'b0);
    pix(11'd40, 10'd40, 8'd0,  8'hC8, 0, 1, 0, 24'h646464);
    pix(11'd41, 10'd40, 8'd0,  8'd0,  0, 0, 0, 24'h000000);
    pix(11'd42, 10'd40, 8'd60, 8'd0,  1, 0, 0, 24'h003C00);
    pix(11'd43, 10'd40, 8'd0,  8'd0,  0, 0, 1, 24'h7F0000);

    // Restart, then restart in the middle of FLASH
    set_gs(3'd1);
    chk("flash_after_restart", flash_active_out, 1'b0);
    pix(11'd50, 10'd50, 8'd0, 8'd0, 0, 0, 0, 24'h000000);
    set_gs(3'd0);
    chk("flash_second_drop", flash_active_out, 1'b1);
    frame_end(1'b0, 24'hFFFFFF, 20'd1);
    frame_end(1'b0, 24'h000000, 20'd0);
    frame_end(1'b0, 24'hFFFFFF, 20'd0);
    chk("flash_after_3_frames", flash_active_out, 1'b1);
    set_gs(3'd1);
    chk("flash_mid_restart", flash_active_out, 1'b0);
    pix(11'd51, 10'd50, 8'd60, 8'd0, 1, 0, 0, 24'h007800);
    pix(11'd52, 10'd50, 8'd0,  8'd0, 0, 0, 0, 24'h000000);
    idle();

    // Frame end coinciding with the drop is not counted
    cur_gs = 3'd0;
    frame_end(1'b0, 24'h000000, 20'd0);
    chk("flash_coincident_drop", flash_active_out, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      frame_end(1'b0, (k % 2 == 1) ? 24'hFFFFFF : 24'h000000, 20'd0);
      if (k == 7) chk("flash_coincident_7", flash_active_out, 1'b1);
    end
    chk("flash_coincident_8", flash_active_out, 1'b0);
    pix(11'd60, 10'd60, 8'd0, 8'hC8, 0, 1, 0, 24'h646464);

    // Reset in the middle of a frame
    set_gs(3'd1);
    pix(11'd70, 10'd70, 8'd0, 8'd0, 0, 0, 1, 24'hFF0000);
    frame_end(1'b0, 24'h000000, 20'd1);
    set_gs(3'd0);
    chk("flash_before_reset", flash_active_out, 1'b1);
    pix(11'd71, 10'd70, 8'd0, 8'd0, 0, 0, 1, 24'h00FFFF);
    pix(11'd72, 10'd70, 8'd0, 8'd0, 0, 0, 1, 24'h00FFFF);
    pix(11'd73, 10'd70, 8'd0, 8'd0, 0, 0, 1, 24'h00FFFF);
    #2;
    rst_in = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    exp_pix_q.delete();
    exp_stats_q.delete();
    data_valid_in = 1'b0;
    cur_gs = 3'd1;
    game_state_in = 3'd1;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    idle();
    chk("flash_after_reset", flash_active_out, 1'b0);
    pix(11'd80, 10'd80, 8'd0, 8'd0, 0, 0, 1, 24'hFF0000);
    pix(11'd81, 10'd80, 8'd0, 8'd0, 1, 0, 1, 24'hFF0000);
    frame_end(1'b0, 24'h000000, 20'd2);

    // Drain with a bounded wait
    for (int i = 0; i < 20; i++) begin
      if (exp_pix_q.size() != 0 || exp_stats_q.size() != 0) idle();
    end
    repeat (2) idle();
    chk("pixel_queue_drained", exp_pix_q.size(), 0);
    chk("stats_queue_drained", exp_stats_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
